// File: rtl/masked_event_counter.sv
// rtl/masked_event_counter.sv - per-channel masked event counter with overflow flags and hit strobe
module masked_event_counter #(
  parameter int NCH  = 4,
  parameter int CW   = 8,
  parameter int SAT  = 0,
  parameter int EDGE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    data,
  input  logic              en,
  input  logic              clr,
  input  logic              mask_wr,
  input  logic [NCH-1:0]    mask_din,
  output logic [NCH*CW-1:0] count,
  output logic [NCH-1:0]    ovf,
  output logic              any_hit
);

  logic [NCH-1:0]         mask_q;
  logic [NCH-1:0]         data_q;
  logic [NCH-1:0]         ev;
  logic [NCH-1:0]         q;
  logic [NCH-1:0][CW-1:0] cnt_q;
  logic [NCH-1:0][CW-1:0] cnt_d;
  logic [NCH-1:0][CW:0]   sum;
  logic [NCH-1:0]         ovf_q;
  logic [NCH-1:0]         ovf_d;
  logic                   hit_q;
  logic                   hit_d;

  // Edge mode only counts a low-to-high transition against last cycle's sample.
  always_comb begin
    if (EDGE != 0) begin
      ev = data & ~data_q;
    end else begin
      ev = data;
    end
    q = {NCH{en}} & mask_q & ev;
  end

  // The extra adder bit is the all-ones detect; it never reaches a register.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    sum   = '0;
    hit_d = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      sum[i] = {1'b0, cnt_q[i]} + {{CW{1'b0}}, 1'b1};
      if (clr) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (q[i]) begin
        if (!sum[i][CW]) begin
          cnt_d[i] = sum[i][CW-1:0];
        end else begin
          ovf_d[i] = 1'b1;
          if (SAT == 0) begin
            cnt_d[i] = sum[i][CW-1:0];
          end
        end
      end
    end
    if (!clr) begin
      hit_d = |q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '1;
      data_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= '0;
      hit_q  <= 1'b0;
    end else begin
      data_q <= data;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      hit_q  <= hit_d;
      if (mask_wr) begin
        mask_q <= mask_din;
      end
    end
  end

  assign count   = cnt_q;
  assign ovf     = ovf_q;
  assign any_hit = hit_q;

endmodule

// File: tb/tb_masked_event_counter.sv
// tb/tb_masked_event_counter.sv - directed self-checking bench for masked_event_counter
module tb_masked_event_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  data;
  logic        en;
  logic        clr;
  logic        mask_wr;
  logic [3:0]  mask_din;

  logic [31:0] cnt0, cnt3;
  logic [15:0] cnt1, cnt2;
  logic [3:0]  ovf0, ovf1, ovf2, ovf3;
  logic        hit0, hit1, hit2, hit3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // u0: level/wrap CW8, u1: CW4 wrap, u2: CW4 saturate, u3: edge mode CW8
  masked_event_counter #(.NCH(4), .CW(8), .SAT(0), .EDGE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .data(data), .en(en), .clr(clr), .mask_wr(mask_wr),
    .mask_din(mask_din), .count(cnt0), .ovf(ovf0), .any_hit(hit0));
  masked_event_counter #(.NCH(4), .CW(4), .SAT(0), .EDGE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .data(data), .en(en), .clr(clr), .mask_wr(mask_wr),
    .mask_din(mask_din), .count(cnt1), .ovf(ovf1), .any_hit(hit1));
  masked_event_counter #(.NCH(4), .CW(4), .SAT(1), .EDGE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .data(data), .en(en), .clr(clr), .mask_wr(mask_wr),
    .mask_din(mask_din), .count(cnt2), .ovf(ovf2), .any_hit(hit2));
  masked_event_counter #(.NCH(4), .CW(8), .SAT(0), .EDGE(1)) u3 (
    .clk(clk), .rst_n(rst_n), .data(data), .en(en), .clr(clr), .mask_wr(mask_wr),
    .mask_din(mask_din), .count(cnt3), .ovf(ovf3), .any_hit(hit3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; reset pulse stays clear of both edges.
  task automatic do_reset();
    data = '0; en = 1'b0; clr = 1'b0; mask_wr = 1'b0; mask_din = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; data = '0; en = 1'b0; clr = 1'b0; mask_wr = 1'b0; mask_din = '0;
    step(2);
    check("rst_count", cnt0, 32'h0);
    check("rst_ovf", {28'h0, ovf0}, 32'h0);
    check("rst_hit", {31'h0, hit0}, 32'h0);
    rst_n = 1'b1;

    // level counting on channels 0 and 2
    step(1);
    data = 4'b0101; en = 1'b1;
    step(1);
    check("lvl_hit_first", {31'h0, hit0}, 32'h1);
    check("lvl_cnt_first", cnt0, 32'h00010001);
    step(2);
    check("lvl_cnt3", cnt0, 32'h00030003);

    // wrap vs saturate at CW=4
    do_reset();
    data = 4'b0001; en = 1'b1;
    step(15);
    check("wrap_at_max", {16'h0, cnt1}, 32'h000F);
    check("wrap_no_ovf_yet", {28'h0, ovf1}, 32'h0);
    step(2);
    check("wrap_cnt", {16'h0, cnt1}, 32'h0001);
    check("wrap_ovf", {28'h0, ovf1}, 32'h1);
    check("sat_cnt", {16'h0, cnt2}, 32'h000F);
    check("sat_ovf", {28'h0, ovf2}, 32'h1);
    check("sat_hit", {31'h0, hit2}, 32'h1);
    check("edge_held_once", cnt3, 32'h00000001);

    // clr beats a qualified event and clears sticky ovf
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr_cnt", {16'h0, cnt1}, 32'h0);
    check("clr_ovf", {28'h0, ovf1}, 32'h0);
    check("clr_hit", {31'h0, hit1}, 32'h0);

    // mask load: loading cycle still uses the old mask
    do_reset();
    data = 4'hF; en = 1'b1; mask_wr = 1'b1; mask_din = 4'b0010;
    step(1);
    mask_wr = 1'b0;
    check("mask_load_cycle", cnt0, 32'h01010101);
    step(2);
    check("mask_applied", cnt0, 32'h01010301);
    check("mask_hit", {31'h0, hit0}, 32'h1);

    // clr and mask_wr together both take effect
    clr = 1'b1; mask_wr = 1'b1; mask_din = 4'b1000;
    step(1);
    clr = 1'b0; mask_wr = 1'b0;
    check("clr_mask_cnt", cnt0, 32'h0);
    step(1);
    check("clr_mask_new", cnt0, 32'h01000000);

    // edge mode: 0,1,1,0,1 gives two rising edges
    do_reset();
    en = 1'b1;
    data = 4'b0000; step(1);
    data = 4'b0001; step(1);
    data = 4'b0001; step(1);
    data = 4'b0000; step(1);
    data = 4'b0001; step(1);
    check("edge_cnt", cnt3, 32'h00000002);
    check("edge_ovf", {28'h0, ovf3}, 32'h0);

    // first edge passes while disabled and is not counted later
    do_reset();
    data = 4'b0000; en = 1'b1; step(1);
    data = 4'b0001; en = 1'b0; step(1);
    data = 4'b0001; en = 1'b1; step(1);
    data = 4'b0000; step(1);
    data = 4'b0001; step(1);
    check("edge_en_low", cnt3, 32'h00000001);
    check("edge_en_hit", {31'h0, hit3}, 32'h1);

    // line already high when reset releases counts once in edge mode
    rst_n = 1'b0; data = 4'hF; en = 1'b1;
    #2;
    rst_n = 1'b1;
    step(1);
    check("edge_after_rst", cnt3, 32'h01010101);
    step(2);
    check("edge_held_high", cnt3, 32'h01010101);
    check("lvl_before_rst", cnt0, 32'h03030303);

    // mask everything off, then async reset must restore outputs and mask
    mask_wr = 1'b1; mask_din = 4'b0000;
    step(1);
    mask_wr = 1'b0;
    step(1);
    check("mask_zero_cnt", cnt0, 32'h04040404);
    check("mask_zero_hit", {31'h0, hit0}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("async_rst_cnt", cnt0, 32'h0);
    check("async_rst_ovf", {28'h0, ovf1}, 32'h0);
    check("async_rst_hit", {31'h0, hit0}, 32'h0);
    rst_n = 1'b1;
    step(1);
    check("mask_reset_ones", cnt0, 32'h01010101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
